core_decode_pipe: RTL and testbench

CORE_DECODE_PIPE -- requirements
Module: core_decode_pipe

---
 rtl/core_decode_pipe_if.sv | 61 ++++++
 rtl/core_decode_pipe.sv | 246 ++++++++++++++++++++++++
 tb/tb_core_decode_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_decode_pipe_if.sv
// ---------------------------------------------------------------------------
// core_decode_pipe_if
// Groups the handshake, writeback and decoded-output signals of the decode
// stage. Clock and reset are plain module ports and are not part of it.
//
// Signals (direction as seen by the decode stage, i.e. the slave modport):
//   i_valid, i_instr[31:0], i_pc[XLEN-1:0]    upstream instruction
//   o_ready                                   decode accepts this cycle
//   i_flush                                   kill decode-output contents
//   i_ex_ready                                downstream accepts output
//   i_wb_reg_write, i_wb_rd[4:0], i_wb_data   register writeback port
//   o_valid, o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7,
//   o_imm, o_rs1_dout, o_rs2_dout,
//   o_mem_read, o_mem_write, o_reg_write, o_illegal   decoded bundle
// ---------------------------------------------------------------------------
interface core_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic            i_ex_ready;
  logic            i_wb_reg_write;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [6:0]      o_opcode;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [2:0]      o_funct3;
  logic [6:0]      o_funct7;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_rs1_dout;
  logic [XLEN-1:0] o_rs2_dout;
  logic            o_mem_read;
  logic            o_mem_write;
  logic            o_reg_write;
  logic            o_illegal;

  // Decode stage side
  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ex_ready,
           i_wb_reg_write, i_wb_rd, i_wb_data,
    output o_ready, o_valid, o_pc, o_opcode, o_rd, o_rs1, o_rs2,
           o_funct3, o_funct7, o_imm, o_rs1_dout, o_rs2_dout,
           o_mem_read, o_mem_write, o_reg_write, o_illegal
  );

  // Fetch / execute / writeback side
  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ex_ready,
           i_wb_reg_write, i_wb_rd, i_wb_data,
    input  o_ready, o_valid, o_pc, o_opcode, o_rd, o_rs1, o_rs2,
           o_funct3, o_funct7, o_imm, o_rs1_dout, o_rs2_dout,
           o_mem_read, o_mem_write, o_reg_write, o_illegal
  );
endinterface

// File: rtl/core_decode_pipe.sv
// ---------------------------------------------------------------------------
// core_decode_pipe
// RISC-V instruction decode stage with integrated register file. Decodes one
// instruction per cycle into a registered output bundle (1-cycle latency),
// reads two operands from the register file (optionally forwarding a
// same-cycle writeback), detects load-use hazards against the instruction
// currently held in the output register, and supports stall and flush.
//
// Ports:
//   i_clk   sole clock, rising edge
//   i_rst   synchronous active-high reset (clears outputs and register file)
//   bus     core_decode_pipe_if.slave: handshake, writeback, decoded bundle
//
// Parameters:
//   XLEN       datapath width (32 or 64)
//   NREGS      architectural register count (16 or 32)
//   WB_BYPASS  1: forward same-cycle writeback data to the read ports
// ---------------------------------------------------------------------------
module core_decode_pipe #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  core_decode_pipe_if.slave bus
);

  localparam int         RW        = $clog2(NREGS);
  localparam logic [5:0] NREGS_LIM = 6'(NREGS);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1Dout;
    logic [XLEN-1:0] rs2Dout;
    logic            memRead;
    logic            memWrite;
    logic            regWrite;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0]   regs_q [NREGS];
  bundle_t           bundle_q, bundle_d, decoded;
  logic              valid_q, valid_d;
  logic [31:0]       instr;
  logic signed [31:0] imm32;
  logic              legalOpc, usesRs1, usesRs2, usesRd, isLoad, isStore;
  logic              rangeBad, illegal;
  logic [XLEN-1:0]   rs1Val, rs2Val;
  logic              wbEn, ld, hazard, ready, accept;

  // Register indices beyond NREGS do not exist (RV-E has only 16).
  function automatic logic inRange(input logic [4:0] idx);
    return ({1'b0, idx} < NREGS_LIM);
  endfunction

  assign instr = bus.i_instr;
  assign wbEn  = bus.i_wb_reg_write && (bus.i_wb_rd != 5'd0) && inRange(bus.i_wb_rd);

  // Opcode classification and immediate extraction. Only the register fields
  // an instruction actually uses take part in the out-of-range check, since
  // the other field positions carry immediate bits.
  always_comb begin
    imm32    = '0;
    legalOpc = 1'b1;
    usesRs1  = 1'b1;
    usesRs2  = 1'b0;
    usesRd   = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    unique case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm32   = {instr[31:12], 12'b0};
        usesRs1 = 1'b0;
        usesRd  = 1'b1;
      end
      OPC_JAL: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        usesRs1 = 1'b0;
        usesRd  = 1'b1;
      end
      OPC_JALR, OPC_OPIMM, OPC_SYSTEM: begin
        imm32  = {{20{instr[31]}}, instr[31:20]};
        usesRd = 1'b1;
      end
      OPC_LOAD: begin
        imm32  = {{20{instr[31]}}, instr[31:20]};
        usesRd = 1'b1;
        isLoad = 1'b1;
      end
      OPC_MISCMEM: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        usesRs2 = 1'b1;
        isStore = 1'b1;
      end
      OPC_BRANCH: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        usesRs2 = 1'b1;
      end
      OPC_OP: begin
        usesRs2 = 1'b1;
        usesRd  = 1'b1;
      end
      default: begin
        legalOpc = 1'b0;
      end
    endcase
    rangeBad = (usesRd  && !inRange(instr[11:7]))  ||
               (usesRs1 && !inRange(instr[19:15])) ||
               (usesRs2 && !inRange(instr[24:20]));
    illegal  = !legalOpc || rangeBad;
  end

  // Read port 1: x0 and nonexistent registers read as zero; a same-cycle
  // writeback to the addressed register is forwarded when bypass is enabled.
  always_comb begin
    rs1Val = '0;
    if ((instr[19:15] != 5'd0) && inRange(instr[19:15])) begin
      if ((WB_BYPASS != 0) && wbEn && (bus.i_wb_rd == instr[19:15])) begin
        rs1Val = bus.i_wb_data;
      end else begin
        rs1Val = regs_q[instr[15+RW-1:15]];
      end
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    rs2Val = '0;
    if ((instr[24:20] != 5'd0) && inRange(instr[24:20])) begin
      if ((WB_BYPASS != 0) && wbEn && (bus.i_wb_rd == instr[24:20])) begin
        rs2Val = bus.i_wb_data;
      end else begin
        rs2Val = regs_q[instr[20+RW-1:20]];
      end
    end
  end

  // Assemble the bundle that would be loaded if the instruction is accepted.
  always_comb begin
    decoded          = '0;
    decoded.pc       = bus.i_pc;
    decoded.opcode   = instr[6:0];
    decoded.rd       = instr[11:7];
    decoded.rs1      = instr[19:15];
    decoded.rs2      = instr[24:20];
    decoded.funct3   = instr[14:12];
    decoded.funct7   = instr[31:25];
    decoded.imm      = XLEN'(imm32);
    decoded.rs1Dout  = rs1Val;
    decoded.rs2Dout  = rs2Val;
    decoded.memRead  = isLoad && !illegal;
    decoded.memWrite = isStore && !illegal;
    decoded.regWrite = usesRd && (instr[11:7] != 5'd0) && !illegal;
    decoded.illegal  = illegal;
  end

  // Handshake: the output register can load when empty or being drained.
  // A load in the output register whose destination is needed by the incoming
  // instruction blocks acceptance, which yields exactly one bubble.
  always_comb begin
    ld     = !valid_q || bus.i_ex_ready;
    hazard = valid_q && bundle_q.memRead && (bundle_q.rd != 5'd0) && bus.i_valid &&
             ((usesRs1 && (instr[19:15] == bundle_q.rd)) ||
              (usesRs2 && (instr[24:20] == bundle_q.rd)));
    ready  = ld && !hazard && !bus.i_flush && !i_rst;
    accept = bus.i_valid && ready;
  end

  // Next-state of the output stage: flush empties it, a load slot either
  // takes the new instruction or becomes a bubble, otherwise everything holds.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (bus.i_flush) begin
      valid_d = 1'b0;
    end else if (ld) begin
      valid_d = accept;
      if (accept) begin
        bundle_d = decoded;
      end
    end
  end

  // Output stage registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  // Register file write port; writeback is independent of stall and flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wbEn) begin
      regs_q[bus.i_wb_rd[RW-1:0]] <= bus.i_wb_data;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_pc        = bundle_q.pc;
  assign bus.o_opcode    = bundle_q.opcode;
  assign bus.o_rd        = bundle_q.rd;
  assign bus.o_rs1       = bundle_q.rs1;
  assign bus.o_rs2       = bundle_q.rs2;
  assign bus.o_funct3    = bundle_q.funct3;
  assign bus.o_funct7    = bundle_q.funct7;
  assign bus.o_imm       = bundle_q.imm;
  assign bus.o_rs1_dout  = bundle_q.rs1Dout;
  assign bus.o_rs2_dout  = bundle_q.rs2Dout;
  assign bus.o_mem_read  = bundle_q.memRead;
  assign bus.o_mem_write = bundle_q.memWrite;
  assign bus.o_reg_write = bundle_q.regWrite;
  assign bus.o_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_core_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_core_decode_pipe
// Directed bench for core_decode_pipe. Instance dut uses the defaults
// (XLEN=32, NREGS=32, WB_BYPASS=1); instance dut16 uses NREGS=16 and
// WB_BYPASS=0. Inputs change on the falling edge; o_ready is sampled 1 ns
// later and registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_core_decode_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  core_decode_pipe_if #(.XLEN(32)) bus ();
  core_decode_pipe_if #(.XLEN(32)) bus16 ();

  core_decode_pipe #(.XLEN(32), .NREGS(32), .WB_BYPASS(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  core_decode_pipe #(.XLEN(32), .NREGS(16), .WB_BYPASS(0)) dut16 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Format vectors: instruction, expected imm, expected {mem_read, mem_write, reg_write, illegal}
  logic [31:0] vecInstr [8] = '{32'h0020A423, 32'hFE208EE3, 32'h123453B7, 32'h010000EF,
                                32'hFFF00413, 32'hFFFFFFFF, 32'h0000A103, 32'h000104B7};
  logic [31:0] vecImm   [8] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000010,
                                32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00010000};
  logic [3:0]  vecFlags [8] = '{4'b0100, 4'b0000, 4'b0010, 4'b0010,
                                4'b0010, 4'b0001, 4'b1010, 4'b0010};

  // Drive the main instance's upstream/downstream controls on a falling edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic exReady,
                               input logic flush);
    @(negedge clk);
    bus.i_valid    = valid;
    bus.i_instr    = instr;
    bus.i_pc       = pc;
    bus.i_ex_ready = exReady;
    bus.i_flush    = flush;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %0b want 0", bus.o_ready);
    end
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rd, bus.o_imm, bus.o_pc, bus.o_reg_write} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%0b rd=%0d imm=%h pc=%h rw=%0b want all 0",
               bus.o_valid, bus.o_rd, bus.o_imm, bus.o_pc, bus.o_reg_write);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  task automatic test_addi();
    applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL addi_ready: got %0b want 1", bus.o_ready);
    end
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rd, bus.o_imm, bus.o_reg_write, bus.o_illegal, bus.o_pc} !==
        {1'b1, 5'd1, 32'd5, 1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("[TB] FAIL addi_bundle: valid=%0b rd=%0d imm=%h rw=%0b ill=%0b pc=%h want 1 1 00000005 1 0 00000100",
               bus.o_valid, bus.o_rd, bus.o_imm, bus.o_reg_write, bus.o_illegal, bus.o_pc);
    end
    applyStimulus(1'b0, 32'h00000013, 32'h104, 1'b1, 1'b0);
    afterEdge();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_bubble: got %0b want 0", bus.o_valid);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 32'h0000A103, 32'h110, 1'b1, 1'b0);
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_mem_read, bus.o_rd} !== {1'b1, 1'b1, 5'd2}) begin
      errors++;
      $display("[TB] FAIL lw_bundle: valid=%0b mr=%0b rd=%0d want 1 1 2",
               bus.o_valid, bus.o_mem_read, bus.o_rd);
    end
    applyStimulus(1'b1, 32'h002101B3, 32'h114, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hazard_ready: got %0b want 0", bus.o_ready);
    end
    afterEdge();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hazard_bubble: got %0b want 0", bus.o_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hazard_release_ready: got %0b want 1", bus.o_ready);
    end
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_mem_read, bus.o_reg_write, bus.o_pc} !==
        {1'b1, 5'd3, 5'd2, 5'd2, 1'b0, 1'b1, 32'h114}) begin
      errors++;
      $display("[TB] FAIL add_after_load: valid=%0b rd=%0d rs1=%0d rs2=%0d mr=%0b rw=%0b pc=%h want 1 3 2 2 0 1 00000114",
               bus.o_valid, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_mem_read, bus.o_reg_write, bus.o_pc);
    end
  endtask

  task automatic test_wb_bypass();
    applyStimulus(1'b1, 32'h000202B3, 32'h120, 1'b1, 1'b0);
    bus.i_wb_reg_write = 1'b1;
    bus.i_wb_rd        = 5'd4;
    bus.i_wb_data      = 32'hDEADBEEF;
    afterEdge();
    checks++;
    if ({bus.o_rs1_dout, bus.o_rs2_dout} !== {32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("[TB] FAIL wb_bypass: rs1=%h rs2=%h want deadbeef 00000000",
               bus.o_rs1_dout, bus.o_rs2_dout);
    end
    applyStimulus(1'b1, 32'h00420333, 32'h124, 1'b1, 1'b0);
    bus.i_wb_reg_write = 1'b0;
    afterEdge();
    checks++;
    if ({bus.o_rs1_dout, bus.o_rs2_dout} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL wb_stored: rs1=%h rs2=%h want deadbeef deadbeef",
               bus.o_rs1_dout, bus.o_rs2_dout);
    end
    applyStimulus(1'b1, 32'h000002B3, 32'h128, 1'b1, 1'b0);
    bus.i_wb_reg_write = 1'b1;
    bus.i_wb_rd        = 5'd0;
    bus.i_wb_data      = 32'd7;
    afterEdge();
    checks++;
    if (bus.o_rs1_dout !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_no_bypass: got %h want 00000000", bus.o_rs1_dout);
    end
    applyStimulus(1'b1, 32'h000002B3, 32'h12C, 1'b1, 1'b0);
    bus.i_wb_reg_write = 1'b0;
    afterEdge();
    checks++;
    if (bus.o_rs1_dout !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_write_ignored: got %h want 00000000", bus.o_rs1_dout);
    end
  endtask

  task automatic test_imm_formats();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecInstr[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fmt_ready[%0d]: got %0b want 1", i, bus.o_ready);
      end
      afterEdge();
      checks++;
      if ({bus.o_valid, bus.o_opcode, bus.o_imm,
           bus.o_mem_read, bus.o_mem_write, bus.o_reg_write, bus.o_illegal} !==
          {1'b1, vecInstr[i][6:0], vecImm[i], vecFlags[i]}) begin
        errors++;
        $display("[TB] FAIL fmt_decode[%0d]: valid=%0b opc=%h imm=%h flags=%b want 1 %h %h %b",
                 i, bus.o_valid, bus.o_opcode, bus.o_imm,
                 {bus.o_mem_read, bus.o_mem_write, bus.o_reg_write, bus.o_illegal},
                 vecInstr[i][6:0], vecImm[i], vecFlags[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    applyStimulus(1'b1, 32'h00500093, 32'h300, 1'b1, 1'b0);
    afterEdge();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h002101B3, 32'h304, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.o_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_ready[%0d]: got %0b want 0", c, bus.o_ready);
      end
      afterEdge();
      checks++;
      if ({bus.o_valid, bus.o_rd, bus.o_imm, bus.o_pc} !== {1'b1, 5'd1, 32'd5, 32'h300}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%0b rd=%0d imm=%h pc=%h want 1 1 00000005 00000300",
                 c, bus.o_valid, bus.o_rd, bus.o_imm, bus.o_pc);
      end
    end
    applyStimulus(1'b1, 32'h002101B3, 32'h304, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_ready: got %0b want 0", bus.o_ready);
    end
    afterEdge();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_valid: got %0b want 0", bus.o_valid);
    end
    applyStimulus(1'b1, 32'h002101B3, 32'h304, 1'b1, 1'b0);
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rd, bus.o_pc} !== {1'b1, 5'd3, 32'h304}) begin
      errors++;
      $display("[TB] FAIL after_flush: valid=%0b rd=%0d pc=%h want 1 3 00000304",
               bus.o_valid, bus.o_rd, bus.o_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 32'hFFF00413, 32'h400, 1'b0, 1'b0);
    afterEdge();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_ready: got %0b want 0", bus.o_ready);
    end
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rd, bus.o_imm} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: valid=%0b rd=%0d imm=%h want 0 0 00000000",
               bus.o_valid, bus.o_rd, bus.o_imm);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h00420333, 32'h404, 1'b1, 1'b0);
    afterEdge();
    checks++;
    if ({bus.o_valid, bus.o_rs1_dout, bus.o_rs2_dout} !== {1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL regfile_cleared: valid=%0b rs1=%h rs2=%h want 1 00000000 00000000",
               bus.o_valid, bus.o_rs1_dout, bus.o_rs2_dout);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_nregs16();
    @(negedge clk);
    bus16.i_valid = 1'b1;
    bus16.i_instr = 32'h00100A13;
    bus16.i_pc    = 32'h500;
    afterEdge();
    checks++;
    if ({bus16.o_valid, bus16.o_rd, bus16.o_illegal, bus16.o_reg_write} !== {1'b1, 5'd20, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rve_x20: valid=%0b rd=%0d ill=%0b rw=%0b want 1 20 1 0",
               bus16.o_valid, bus16.o_rd, bus16.o_illegal, bus16.o_reg_write);
    end
    @(negedge clk);
    bus16.i_instr        = 32'h00018333;
    bus16.i_wb_reg_write = 1'b1;
    bus16.i_wb_rd        = 5'd3;
    bus16.i_wb_data      = 32'h11;
    afterEdge();
    checks++;
    if ({bus16.o_rs1_dout, bus16.o_illegal, bus16.o_reg_write} !== {32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL nobypass_old: rs1=%h ill=%0b rw=%0b want 00000000 0 1",
               bus16.o_rs1_dout, bus16.o_illegal, bus16.o_reg_write);
    end
    @(negedge clk);
    bus16.i_wb_reg_write = 1'b0;
    afterEdge();
    checks++;
    if (bus16.o_rs1_dout !== 32'h11) begin
      errors++;
      $display("[TB] FAIL nobypass_new: got %h want 00000011", bus16.o_rs1_dout);
    end
    @(negedge clk);
    bus16.i_instr        = 32'h000002B3;
    bus16.i_wb_reg_write = 1'b1;
    bus16.i_wb_rd        = 5'd0;
    bus16.i_wb_data      = 32'd7;
    @(negedge clk);
    bus16.i_wb_reg_write = 1'b0;
    afterEdge();
    checks++;
    if (bus16.o_rs1_dout !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rve_x0: got %h want 00000000", bus16.o_rs1_dout);
    end
    @(negedge clk);
    bus16.i_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.i_valid = 1'b0;   bus.i_instr = '0;   bus.i_pc = '0;
    bus.i_flush = 1'b0;   bus.i_ex_ready = 1'b1;
    bus.i_wb_reg_write = 1'b0; bus.i_wb_rd = '0; bus.i_wb_data = '0;
    bus16.i_valid = 1'b0; bus16.i_instr = '0; bus16.i_pc = '0;
    bus16.i_flush = 1'b0; bus16.i_ex_ready = 1'b1;
    bus16.i_wb_reg_write = 1'b0; bus16.i_wb_rd = '0; bus16.i_wb_data = '0;
    @(posedge clk);
    test_reset();
    test_addi();
    test_load_use();
    test_wb_bypass();
    test_imm_formats();
    test_stall_flush();
    test_reset_mid_stall();
    test_nregs16();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
